// File: rtl/seg7_scan_drv_if.sv
// Display bus between a digit/attribute source and the seven-segment scanner.
// The master owns the digit data and display controls; the slave drives the pins.
interface seg7_scan_drv_if #(
    parameter int N_DIGITS = 8
);
    logic [6*N_DIGITS-1:0] digits;
    logic [N_DIGITS-1:0]   blink_mask;
    logic [2:0]            brightness;
    logic                  blank;
    logic [7:0]            dec_cat;
    logic [N_DIGITS-1:0]   an;

    modport master (
        output digits,
        output blink_mask,
        output brightness,
        output blank,
        input  dec_cat,
        input  an
    );

    modport slave (
        input  digits,
        input  blink_mask,
        input  brightness,
        input  blank,
        output dec_cat,
        output an
    );
endinterface

// File: rtl/seg7_scan_drv.sv
// Multiplexed seven-segment scanner: per-digit hex/dp/enable, blink, PWM brightness, blank.
// Outputs registered with 1-cycle latency; no backpressure, scanning free-runs.
module seg7_scan_drv #(
    parameter int N_DIGITS       = 8,
    parameter int REFRESH_CYCLES = 100000,
    parameter int BLINK_SLOTS    = 500
) (
    input  logic           i_clock,
    input  logic           i_reset,
    seg7_scan_drv_if.slave bus
);
    localparam int CW = $clog2(REFRESH_CYCLES);
    localparam int SW = $clog2(N_DIGITS);
    localparam int BW = $clog2(BLINK_SLOTS) + 1;
    localparam int PW = REFRESH_CYCLES / 8;

    localparam logic [CW-1:0] CNT_LAST   = CW'(REFRESH_CYCLES - 1);
    localparam logic [SW-1:0] SEL_LAST   = SW'(N_DIGITS - 1);
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_SLOTS - 1);

    logic [CW-1:0]       r_cnt;
    logic [SW-1:0]       r_sel;
    logic [BW-1:0]       r_blink_cnt;
    logic                r_blink_phase;
    logic [2:0]          r_bright_q;
    logic [N_DIGITS-1:0] r_an;
    logic [7:0]          r_dec_cat;

    logic                w_slot_tick;
    logic [5:0]          w_dig;
    logic                w_blink_sel;
    logic [CW:0]         w_lit_lim;
    logic                w_lit;
    logic [N_DIGITS-1:0] w_an_nxt;
    logic [7:0]          w_dec_nxt;

    function automatic logic [6:0] seg_font(input logic [3:0] hex);
        logic [6:0] seg;
        case (hex)
            4'h0:    seg = 7'b1000000;
            4'h1:    seg = 7'b1111001;
            4'h2:    seg = 7'b0100100;
            4'h3:    seg = 7'b0110000;
            4'h4:    seg = 7'b0011001;
            4'h5:    seg = 7'b0010010;
            4'h6:    seg = 7'b0000010;
            4'h7:    seg = 7'b1111000;
            4'h8:    seg = 7'b0000000;
            4'h9:    seg = 7'b0010000;
            4'hA:    seg = 7'b0001000;
            4'hB:    seg = 7'b0000011;
            4'hC:    seg = 7'b1000110;
            4'hD:    seg = 7'b0100001;
            4'hE:    seg = 7'b0000110;
            default: seg = 7'b0001110;
        endcase
        return seg;
    endfunction

    assign w_slot_tick = (r_cnt == CNT_LAST);

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_cnt      <= '0;
            r_sel      <= '0;
            r_bright_q <= 3'd7;
        end else if (w_slot_tick) begin
            r_cnt      <= '0;
            r_sel      <= (r_sel == SEL_LAST) ? '0 : r_sel + SW'(1);
            r_bright_q <= bus.brightness;
        end else begin
            r_cnt      <= r_cnt + CW'(1);
        end
    end

    // Blink phase advances on slot boundaries so it always changes together with sel.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_blink_cnt   <= '0;
            r_blink_phase <= 1'b0;
        end else if (w_slot_tick) begin
            if (r_blink_cnt == BLINK_LAST) begin
                r_blink_cnt   <= '0;
                r_blink_phase <= ~r_blink_phase;
            end else begin
                r_blink_cnt   <= r_blink_cnt + BW'(1);
            end
        end
    end

    always_comb begin
        w_dig       = '0;
        w_blink_sel = 1'b0;
        for (int i = 0; i < N_DIGITS; i++) begin
            if (r_sel == SW'(i)) begin
                w_dig       = bus.digits[6*i +: 6];
                w_blink_sel = bus.blink_mask[i];
            end
        end
    end

    // PWM window: lit for the first (bright_q+1) eighths of the slot.
    assign w_lit_lim = (CW+1)'(PW * (int'(r_bright_q) + 1));

    assign w_lit = w_dig[5]
                 & ~bus.blank
                 & ~(w_blink_sel & r_blink_phase)
                 & ({1'b0, r_cnt} < w_lit_lim);

    always_comb begin
        w_an_nxt = '1;
        for (int i = 0; i < N_DIGITS; i++) begin
            if (w_lit && (r_sel == SW'(i))) begin
                w_an_nxt[N_DIGITS-1-i] = 1'b0;
            end
        end
    end

    // Cathodes follow the selected digit even while its anode is dark.
    assign w_dec_nxt = {seg_font(w_dig[4:1]), ~w_dig[0]};

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_an      <= '1;
            r_dec_cat <= 8'hFF;
        end else begin
            r_an      <= w_an_nxt;
            r_dec_cat <= w_dec_nxt;
        end
    end

    assign bus.an      = r_an;
    assign bus.dec_cat = r_dec_cat;
endmodule

// File: tb/tb_seg7_scan_drv.sv
// Directed bench for seg7_scan_drv (4 digits, 16-cycle slots, 4-slot blink half-period).
// A reference model pushes expected pins per edge; the sequence pops and compares them.
module tb_seg7_scan_drv;
    localparam int N = 4;
    localparam int R = 16;
    localparam int B = 4;

    localparam logic [6:0] FONT [0:15] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };

    logic clock = 1'b0;
    logic reset = 1'b1;
    int   checks   = 0;
    int   failures = 0;

    seg7_scan_drv_if #(.N_DIGITS(N)) intf ();

    seg7_scan_drv #(
        .N_DIGITS(N),
        .REFRESH_CYCLES(R),
        .BLINK_SLOTS(B)
    ) dut (
        .i_clock(clock),
        .i_reset(reset),
        .bus    (intf.slave)
    );

    always #5 clock = ~clock;

    // Reference model: expected {an, dec_cat} for each rising edge.
    logic [11:0] exp_q [$];
    int          m_cnt, m_sel, m_bcnt, m_phase, m_bq;
    logic [5:0]  m_dig;
    logic        m_lit;
    logic [3:0]  m_an;

    always @(posedge clock) begin
        if (reset) begin
            exp_q.push_back({4'hF, 8'hFF});
            m_cnt = 0; m_sel = 0; m_bcnt = 0; m_phase = 0; m_bq = 7;
        end else begin
            m_dig = intf.digits[6*m_sel +: 6];
            m_lit = m_dig[5] && !intf.blank && !(intf.blink_mask[m_sel] && (m_phase != 0))
                    && (m_cnt < (R/8) * (m_bq + 1));
            m_an  = m_lit ? ~(4'b1000 >> m_sel) : 4'hF;
            exp_q.push_back({m_an, FONT[m_dig[4:1]], ~m_dig[0]});
            if (m_cnt == R-1) begin
                m_sel = (m_sel + 1) % N;
                m_bq  = int'(intf.brightness);
                if (m_bcnt == B-1) begin
                    m_bcnt  = 0;
                    m_phase = 1 - m_phase;
                end else begin
                    m_bcnt = m_bcnt + 1;
                end
            end
            m_cnt = (m_cnt + 1) % R;
        end
    end

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        logic [11:0] e;
        @(posedge clock);
        #1;
        checks++;
        assert (exp_q.size() != 0) else begin
            failures++;
            $error("FAIL sb_empty observed=0 expected=entry");
        end
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk("sb_an",  {4'b0, intf.an}, {4'b0, e[11:8]});
            chk("sb_dec", intf.dec_cat, e[7:0]);
        end
    endtask

    task automatic cycles(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    // Advance until an takes the given value freshly (after being something else).
    task automatic wait_an(input logic [3:0] val, input string tag);
        int n = 0;
        while (intf.an === val && n < 200) begin tick(); n++; end
        while (intf.an !== val && n < 200) begin tick(); n++; end
        chk(tag, {4'b0, intf.an}, {4'b0, val});
    endtask

    initial begin
        intf.digits     = '0;
        for (int i = 0; i < N; i++) intf.digits[6*i +: 6] = {1'b1, 4'(i), 1'b0};
        intf.blink_mask = '0;
        intf.brightness = 3'd7;
        intf.blank      = 1'b0;

        cycles(3);
        chk("rst_an",  {4'b0, intf.an}, 8'h0F);
        chk("rst_dec", intf.dec_cat, 8'hFF);

        reset = 1'b0;
        tick();
        chk("first_an",  {4'b0, intf.an}, 8'h07);
        chk("first_dec", intf.dec_cat, 8'h81);
        cycles(16);
        chk("slot1_an",  {4'b0, intf.an}, 8'h0B);
        chk("slot1_dec", intf.dec_cat, 8'hF3);
        cycles(64);

        intf.digits[17:12] = {1'b1, 4'hA, 1'b1};
        wait_an(4'b1101, "dig2_an");
        chk("dig2_dec", intf.dec_cat, 8'b0001000_0);
        cycles(64);
        intf.digits[17] = 1'b0;
        cycles(64);
        intf.digits[17] = 1'b1;

        intf.brightness = 3'd2;
        cycles(64);
        wait_an(4'b0111, "pwm_start");
        cycles(5);
        chk("pwm_cnt5", {4'b0, intf.an}, 8'h07);
        tick();
        chk("pwm_cnt6", {4'b0, intf.an}, 8'h0F);
        intf.brightness = 3'd7;
        tick();
        chk("pwm_midslot", {4'b0, intf.an}, 8'h0F);
        cycles(64);

        intf.blink_mask = 4'b0010;
        cycles(200);

        intf.blank = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            chk("blank_an", {4'b0, intf.an}, 8'h0F);
        end
        intf.blank = 1'b0;
        cycles(64);

        wait_an(4'b1110, "dig3_start");
        cycles(8);
        reset = 1'b1;
        tick();
        chk("midrst_an",  {4'b0, intf.an}, 8'h0F);
        chk("midrst_dec", intf.dec_cat, 8'hFF);
        reset = 1'b0;
        tick();
        chk("resume_an",  {4'b0, intf.an}, 8'h07);
        chk("resume_dec", intf.dec_cat, 8'h81);
        cycles(64);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/seg7_scan_drv.md
Name: seg7_scan_drv

Overview:
Parametrised multiplexed seven-segment driver for the Nexys A7 display path, generalising the fixed 8-digit scanner. It scans N_DIGITS digits at a programmable slot period. Per digit it decodes a hex nibble, decimal point and enable. It adds per-digit blinking, global PWM brightness control and global blanking. Anode and cathode outputs are registered and active-low, and drive the board pins directly.

Parameters:
N_DIGITS, 8, number of digits scanned (2..8); sets an width and scan modulus
REFRESH_CYCLES, 100000, clock cycles per digit slot; must be a multiple of 8 and >= 8
BLINK_SLOTS, 500, slot ticks per blink half-period (>= 1)

Ports:
clock  in  1  system clock, all logic on rising edge
reset  in  1  synchronous, active-high reset
digits  in  6*N_DIGITS  per-digit {en, hex[3:0], dp}; digit i = digits[6*i+5:6*i]
blink_mask  in  N_DIGITS  bit i=1: digit i blinks
brightness  in  3  0..7; digit lit (brightness+1)/8 of its slot
blank  in  1  1: all anodes off
dec_cat  out  8  {seg[6:0] gfedcba active-low, ~dp}
an  out  N_DIGITS  active-low anodes; digit i drives an[N_DIGITS-1-i]

Behaviour:
- Reset is synchronous and active-high and applies on the clock edge, including mid-slot. Reset values: slot counter=0, sel=0, blink_cnt=0, blink_phase=0 (visible), bright_q=7, an=all 1s, dec_cat=8'hFF.
- Slot counter cnt counts 0..REFRESH_CYCLES-1 and wraps. slot_tick is asserted when cnt==REFRESH_CYCLES-1.
- On slot_tick, sel advances to sel+1, wrapping from N_DIGITS-1 to 0. It never takes values >= N_DIGITS.
- On slot_tick, brightness is latched into bright_q, so a brightness change takes effect at the next slot boundary only.
- Blink counter: on slot_tick, blink_cnt increments. When blink_cnt==BLINK_SLOTS-1 and slot_tick occurs, blink_cnt resets to 0 and blink_phase toggles.
- Lit condition for the selected digit i:
  - en_i=1
  - blank=0
  - NOT (blink_mask[i] AND blink_phase)
  - cnt < (REFRESH_CYCLES/8)*(bright_q+1)
- bright_q=7 means lit for the full slot. bright_q=0 means lit for the first REFRESH_CYCLES/8 cycles only.
- Outputs are registered. an and dec_cat update one clock after the sel/cnt/input state they reflect. Input changes appear on the outputs on the next edge (1-cycle latency).
- an: only bit N_DIGITS-1-sel is 0 when lit; all other bits are 1. When not lit, an is all 1s.
- dec_cat carries the segment code for hex_sel and ~dp_sel whenever not in reset. It is driven even while the anode is off.
- Segment font, active-low gfedcba:
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000
  - 4=0011001, 5=0010010, 6=0000010, 7=1111000
  - 8=0000000, 9=0010000, A=0001000, b=0000011
  - C=1000110, d=0100001, E=0000110, F=0001110
- Simultaneous events: slot_tick and blink toggle in the same cycle both apply. The new sel and new blink_phase take effect together on the next slot.
- blank does not stop scanning, blinking or the brightness counters.
- The slot counter width is $clog2(REFRESH_CYCLES). The blink counter width is $clog2(BLINK_SLOTS)+1, and it never overflows.

Test Plan:
1. N_DIGITS=4, REFRESH_CYCLES=16, BLINK_SLOTS=4. Reset, with all digits {en=1,hex=i,dp=0}, brightness=7.
   Required: an=1111 and dec_cat=FF during reset. an then cycles 0111,1011,1101,1110, changing every 16 cycles and wrapping. dec_cat[7:1] shows the codes for 0,1,2,3. dec_cat[0]=1.
2. Set digit 2 = {1,4'hA,1} -> while sel=2, dec_cat=8'b0001000_0.
   Set digit 2 en=0 -> an=1111 during its slot; scanning continues.
3. brightness=2 -> in each slot an is active for cnt 0..5 and 1111 for 6..15.
   Change brightness mid-slot -> the current slot is unchanged; the new value applies from the next slot.
4. blink_mask=0010 -> digit 1 is dark for 4-slot windows once every 8 slots. Other digits stay unaffected. blink_phase toggles exactly at the 4th slot_tick.
5. Assert blank for 20 cycles -> an=1111 throughout. After release, sel and cnt continue without resetting.
6. Assert reset mid-slot (sel=3, cnt=9) -> the next cycle shows sel=0, cnt=0, an=1111, dec_cat=FF. Normal scanning resumes from digit 0.
